// File: rtl/io_input_scheduler.sv
// io_input_scheduler
// Feeds the seven IO input channels read by the Core. It arbitrates between
// the DSKY receiver and the AXI sensor bridge, allowing one beat per cycle.
// DSKY words go straight to the live VERB/NOUN registers. AXI beats collect
// in a shadow bank, and a whole frame is copied to the live AXI registers on
// one edge, so the Core never sees a mix of old and new sensor words.
// Optional feature: define IO_SCHED_TIMEOUT_EN to abort AXI frames that sit
// idle in FILL for TIMEOUT_CYCLES cycles.
module io_input_scheduler #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_hold,
   input  logic        i_dsky_valid,
   output logic        o_dsky_ready,
   input  logic        i_dsky_sel,
   input  logic [14:0] i_dsky_data,
   input  logic        i_axi_valid,
   output logic        o_axi_ready,
   input  logic [2:0]  i_axi_sel,
   input  logic [14:0] i_axi_data,
   input  logic        i_axi_last,
   output logic [14:0] o_data_DSKY_VERB,
   output logic [14:0] o_data_DSKY_NOUN,
   output logic [14:0] o_data_AXI_G,
   output logic [14:0] o_data_AXI_M,
   output logic [14:0] o_data_AXI_RA,
   output logic [14:0] o_data_AXI_RB,
   output logic [14:0] o_data_AXI_ATX,
   output logic        o_dsky_update,
   output logic        o_axi_commit,
   output logic        o_err
);
   localparam int W    = 15;
   localparam int NAXI = 5;

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_PEND} state_t;

   state_t       r_state;
   logic         r_last_dsky;     // 1 = the last accepted beat was DSKY
   logic         r_dsky_update;
   logic         r_axi_commit;
   logic         r_err;
   logic [W-1:0] r_verb;
   logic [W-1:0] r_noun;
   logic [W-1:0] r_live   [NAXI];
   logic [W-1:0] r_shadow [NAXI];

   logic            w_dsky_elig;
   logic            w_axi_elig;
   logic            w_dsky_grant;
   logic            w_axi_grant;
   logic            w_sel_legal;
   logic            w_commit;
   logic            w_abort;
   logic [NAXI-1:0] w_sel_hit;

   // Eligibility and round-robin tie-break. These depend only on valid,
   // hold, state and the last-grant bit, never on data.
   assign w_dsky_elig  = i_dsky_valid & ~i_hold;
   assign w_axi_elig   = i_axi_valid & (r_state != ST_PEND);
   assign w_dsky_grant = w_dsky_elig & (~w_axi_elig | ~r_last_dsky);
   assign w_axi_grant  = w_axi_elig & (~w_dsky_elig | r_last_dsky);
   assign w_sel_legal  = (i_axi_sel < 3'd5);
   assign w_commit     = (r_state == ST_PEND) & ~i_hold;

   assign o_dsky_ready = w_dsky_grant;
   assign o_axi_ready  = w_axi_grant;

   // One-hot shadow write enable per AXI channel
   genvar gi;
   generate
      for (gi = 0; gi < NAXI; gi = gi + 1) begin : g_sel
         assign w_sel_hit[gi] = w_axi_grant & (i_axi_sel == 3'(gi));
      end
   endgenerate

`ifdef IO_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_timer;

   // The frame times out after TIMEOUT_CYCLES idle FILL cycles. An accepted
   // beat in the same cycle takes priority over the timeout.
   assign w_abort = (r_state == ST_FILL) & ~w_axi_grant &
                    (r_timer == CW'(TIMEOUT_CYCLES - 1));

   // FILL idle counter; it is held at zero outside FILL and after each beat
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_timer <= '0;
      end else if (r_state != ST_FILL || w_axi_grant || w_abort) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + 1'b1;
      end
   end
`else
   logic w_unused_timeout;
   assign w_abort          = 1'b0;
   assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

   // Frame FSM, arbitration memory, live registers and status pulses
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= ST_IDLE;
         r_last_dsky   <= 1'b0;
         r_dsky_update <= 1'b0;
         r_axi_commit  <= 1'b0;
         r_err         <= 1'b0;
         r_verb        <= '0;
         r_noun        <= '0;
         for (int i = 0; i < NAXI; i++) r_live[i] <= '0;
      end else begin
         r_dsky_update <= w_dsky_grant;
         r_axi_commit  <= w_commit;
         if (w_dsky_grant || w_axi_grant) r_last_dsky <= w_dsky_grant;
         if (w_dsky_grant && !i_dsky_sel) r_verb <= i_dsky_data;
         if (w_dsky_grant &&  i_dsky_sel) r_noun <= i_dsky_data;
         if ((w_axi_grant && !w_sel_legal) || w_abort) r_err <= 1'b1;
         case (r_state)
            ST_IDLE: if (w_axi_grant) r_state <= i_axi_last ? ST_PEND : ST_FILL;
            ST_FILL: begin
               if (w_axi_grant && i_axi_last) r_state <= ST_PEND;
               else if (w_abort)              r_state <= ST_IDLE;
            end
            ST_PEND: begin
               if (w_commit) begin
                  for (int i = 0; i < NAXI; i++) r_live[i] <= r_shadow[i];
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Shadow bank: written by AXI beats even under hold, restored on abort
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NAXI; i++) r_shadow[i] <= '0;
      end else begin
         for (int i = 0; i < NAXI; i++) begin
            if (w_abort)           r_shadow[i] <= r_live[i];
            else if (w_sel_hit[i]) r_shadow[i] <= i_axi_data;
         end
      end
   end

   assign o_data_DSKY_VERB = r_verb;
   assign o_data_DSKY_NOUN = r_noun;
   assign o_data_AXI_G     = r_live[0];
   assign o_data_AXI_M     = r_live[1];
   assign o_data_AXI_RA    = r_live[2];
   assign o_data_AXI_RB    = r_live[3];
   assign o_data_AXI_ATX   = r_live[4];
   assign o_dsky_update    = r_dsky_update;
   assign o_axi_commit     = r_axi_commit;
   assign o_err            = r_err;

endmodule
